// File: rtl/toggle_pulse_gen_if.sv
// Signal bundle between the push-button front end and its user.
// There is no valid/ready handshake: btn_in and enable are plain levels.
// t is a one-cycle strobe; btn_level and busy are levels that may be sampled
// on any cycle. The master drives the inputs and the slave is the pulse generator.
interface toggle_pulse_gen_if;
  logic btn_in;
  logic enable;
  logic t;
  logic btn_level;
  logic busy;

  modport master (
    output btn_in,
    output enable,
    input  t,
    input  btn_level,
    input  busy
  );

  modport slave (
    input  btn_in,
    input  enable,
    output t,
    output btn_level,
    output busy
  );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Push-button front end for a T flip-flop stage.
// It has a 2-flop synchroniser, a debounce FSM and an optional hold-to-repeat
// generator, and it produces clean one-cycle toggle pulses on bus.t.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               reset,
  toggle_pulse_gen_if.slave  bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Terminal counts. With repeat off, RPT_LAST is never used, so it is set to a
  // harmless value instead of REPEAT_CYCLES-1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit RPT_ON = (REPEAT_CYCLES != 0);

  logic [1:0]       sync_q;
  logic             btn_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             level_q, level_d;
  logic             t_q, t_d;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.btn_in};
    end
  end

  assign btn_s = sync_q[1];

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rpt_q   <= '0;
      level_q <= 1'b0;
      t_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      level_q <= level_d;
      t_q     <= t_d;
    end
  end

  // Next-state logic. Counters hold their value unless a rule moves them, and
  // t falls back to 0 on every edge that does not fire a pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    level_d = level_q;
    t_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          t_d     = bus.enable;
          rpt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (RPT_ON && (rpt_q == RPT_LAST)) begin
          t_d   = bus.enable;
          rpt_d = '0;
        end else if (RPT_ON) begin
          rpt_d = rpt_q + CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: go back to HELD and restart the repeat interval.
          state_d = HELD;
          rpt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.t         = t_q;
  assign bus.btn_level = level_q;
  assign bus.busy      = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen. It drives two instances from the same stimulus:
// u_dut has repeat off and u_rpt has an 8-cycle repeat. A run-length reference
// model predicts t/btn_level/busy on every edge, and directed checks cover
// latency, bounce, enable gating and a downstream T flip-flop.
module tb_toggle_pulse_gen;
  localparam int D  = 4;
  localparam int R1 = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic enable;
  logic [1:0] state_dbg0, state_dbg1;

  always #5 clk = ~clk;

  toggle_pulse_gen_if bus0();
  toggle_pulse_gen_if bus1();
  assign bus0.btn_in = btn_in;
  assign bus0.enable = enable;
  assign bus1.btn_in = btn_in;
  assign bus1.enable = enable;

  toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0), .state_dbg(state_dbg0));
  toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R1), .CNT_W(8)) u_rpt (
    .clk(clk), .reset(reset), .bus(bus1), .state_dbg(state_dbg1));

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. The debounced level changes once the synchronised input
  // has held the opposite value for D+1 consecutive edges. Repeat pulses count
  // edges spent held since the last pulse or the last bounce back.
  typedef struct {
    bit s1, s2, prev_bs, level, t, busy;
    int run, since;
  } model_t;

  model_t m0, m1;
  logic [2:0] exp_q[$];

  task automatic model_edge(inout model_t m, input int rpt, input bit rst,
                            input bit b, input bit en);
    bit bs;
    if (rst) begin
      m = '{default: 0};
    end else begin
      bs = m.s2;
      m.s2 = m.s1;
      m.s1 = b;
      if (bs == m.prev_bs) begin
        if (m.run < 100000) m.run++;
      end else begin
        m.run = 1;
      end
      m.t = 1'b0;
      if (!m.level) begin
        if (bs && m.run == D + 1) begin
          m.level = 1'b1;
          m.t = en;
          m.since = 0;
        end
      end else if (!bs) begin
        if (m.run == D + 1) m.level = 1'b0;
      end else if (!m.prev_bs) begin
        m.since = 0;
      end else if (rpt != 0) begin
        if (m.since == rpt - 1) begin
          m.t = en;
          m.since = 0;
        end else begin
          m.since++;
        end
      end
      m.prev_bs = bs;
      m.busy = m.level | bs;
    end
  endtask

  int  ecount = 0;
  int  pc0 = 0, pc1 = 0;
  int  pulse_edge0 = -1;
  int  fall_edge0 = -1;
  bit  prev_level0 = 1'b0;
  bit  saw_level0 = 1'b0;
  bit  q = 1'b0;
  int  pulse_times1[$];

  // One clock edge: update the model, then compare both DUTs 1 time unit later.
  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    ecount++;
    model_edge(m0, 0, reset, btn_in, enable);
    model_edge(m1, R1, reset, btn_in, enable);
    exp_q.push_back({m0.t, m0.level, m0.busy});
    exp_q.push_back({m1.t, m1.level, m1.busy});
    #1;
    e = exp_q.pop_front();
    check_val("dut_t", 32'(bus0.t), 32'(e[2]));
    check_val("dut_level", 32'(bus0.btn_level), 32'(e[1]));
    check_val("dut_busy", 32'(bus0.busy), 32'(e[0]));
    e = exp_q.pop_front();
    check_val("rpt_t", 32'(bus1.t), 32'(e[2]));
    check_val("rpt_level", 32'(bus1.btn_level), 32'(e[1]));
    check_val("rpt_busy", 32'(bus1.busy), 32'(e[0]));
    if (bus0.t) begin
      pc0++;
      pulse_edge0 = ecount;
      q = ~q;
    end
    if (bus1.t) begin
      pc1++;
      pulse_times1.push_back(ecount);
    end
    if (bus0.btn_level) saw_level0 = 1'b1;
    if (prev_level0 && !bus0.btn_level) fall_edge0 = ecount;
    prev_level0 = bus0.btn_level;
  endtask

  task automatic hold(input int n, input bit b);
    for (int i = 0; i < n; i++) begin
      btn_in = b;
      step();
    end
  endtask

  task automatic clear_counts();
    pc0 = 0;
    pc1 = 0;
    pulse_edge0 = -1;
    fall_edge0 = -1;
    saw_level0 = 1'b0;
    pulse_times1.delete();
  endtask

  int k, j;

  initial begin
    reset  = 1'b1;
    btn_in = 1'b1;
    enable = 1'b1;
    #1;

    // Reset holds every output low even with the button pressed.
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("reset_t", 32'(bus0.t), 32'd0);
      check_val("reset_level", 32'(bus0.btn_level), 32'd0);
      check_val("reset_busy", 32'(bus0.busy), 32'd0);
    end
    reset = 1'b0;
    hold(10, 1'b0);
    clear_counts();

    // Clean press of 20 cycles: one pulse at k+6, level falls 6 edges after release.
    btn_in = 1'b1;
    k = ecount + 1;
    hold(20, 1'b1);
    j = ecount + 1;
    hold(15, 1'b0);
    check_val("press_pulses", 32'(pc0), 32'd1);
    check_val("press_pulse_edge", 32'(pulse_edge0), 32'(k + D + 2));
    check_val("press_fall_edge", 32'(fall_edge0), 32'(j + D + 2));
    clear_counts();

    // Short glitch: rejected.
    hold(3, 1'b1);
    hold(12, 1'b0);
    check_val("glitch_pulses", 32'(pc0), 32'd0);
    check_val("glitch_level_seen", 32'(saw_level0), 32'd0);
    check_val("glitch_busy", 32'(bus0.busy), 32'd0);
    clear_counts();

    // Release bounce 1,0,1,1,0 and then stable 0.
    hold(12, 1'b1);
    hold(1, 1'b1);
    hold(1, 1'b0);
    hold(2, 1'b1);
    btn_in = 1'b0;
    j = ecount + 1;
    hold(15, 1'b0);
    check_val("bounce_pulses", 32'(pc0), 32'd1);
    check_val("bounce_fall_edge", 32'(fall_edge0), 32'(j + D + 2));
    clear_counts();

    // Held 30 cycles: the repeat instance pulses at k+6, k+14, k+22, k+30.
    btn_in = 1'b1;
    k = ecount + 1;
    hold(30, 1'b1);
    hold(15, 1'b0);
    check_val("repeat_pulses", 32'(pc1), 32'd4);
    check_val("repeat_single", 32'(pc0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (pulse_times1.size() > 0)
        check_val("repeat_edge", 32'(pulse_times1.pop_front()), 32'(k + D + 2 + i * R1));
      else
        check_val("repeat_edge_missing", 32'd0, 32'd1);
    end
    clear_counts();

    // Disabled press: no pulse, level still tracks. Then two enabled presses toggle q.
    enable = 1'b0;
    hold(15, 1'b1);
    hold(12, 1'b0);
    enable = 1'b1;
    hold(3, 1'b0);
    check_val("disabled_pulses", 32'(pc0 + pc1), 32'd0);
    check_val("disabled_level_seen", 32'(saw_level0), 32'd1);
    q = 1'b0;
    hold(12, 1'b1);
    hold(12, 1'b0);
    check_val("tff_q_first", 32'(q), 32'd1);
    hold(12, 1'b1);
    hold(12, 1'b0);
    check_val("tff_q_second", 32'(q), 32'd0);
    clear_counts();

    // Reset in the middle of a held press: a fresh debounce yields exactly one new pulse.
    hold(8, 1'b1);
    reset = 1'b1;
    hold(2, 1'b1);
    check_val("midreset_busy", 32'(bus0.busy), 32'd0);
    reset = 1'b0;
    clear_counts();
    hold(15, 1'b1);
    hold(12, 1'b0);
    check_val("midreset_pulses", 32'(pc0), 32'd1);

    // Randomised segments of constant level, including bounce-length runs,
    // occasional enable changes and rare resets.
    for (int s = 0; s < 60; s++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
      if ($urandom_range(0, 4) == 0) enable = ~enable;
      reset = ($urandom_range(0, 19) == 0);
      btn_in = ~btn_in;
      step();
      reset = 1'b0;
      hold(len, btn_in);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
